// File: rtl/dbg_program_loader.sv
// Debug program loader: streams N instruction words into core instruction memory
// while holding the core in reset. Optional checksum: define DBG_LOADER_CHECKSUM_EN.
module dbg_program_loader #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int ADDR_STEP          = 4,
  parameter int MAX_WORDS          = 1024,
  parameter int SETTLE_CYCLES      = 1,
  parameter int CW                 = $clog2(MAX_WORDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [INSTRUCTION_LENGTH-1:0] base_addr,
  input  logic [CW-1:0]                 word_count,
  input  logic                          in_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] in_data,
  output logic                          in_ready,
  output logic                          dbg_wr_en,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [CW-1:0]                 loaded_count,
`ifdef DBG_LOADER_CHECKSUM_EN
  input  logic [INSTRUCTION_LENGTH-1:0] exp_sum,
  output logic                          sum_err,
`endif
  output logic [2:0]                    state_dbg
);
  localparam int IL = INSTRUCTION_LENGTH;
  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [IL-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] loaded_q, loaded_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          wr_en_q, wr_en_d;
  logic [IL-1:0] wr_addr_q, wr_addr_d;
  logic [IL-1:0] wr_data_q, wr_data_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          xfer;
`ifdef DBG_LOADER_CHECKSUM_EN
  logic [IL-1:0] sum_q, sum_d;
  logic [IL-1:0] exp_q, exp_d;
  logic          sum_err_q, sum_err_d;
`endif

  // Handshake: a word is accepted on a rising edge where in_valid && in_ready.
  // in_ready drops during abort so an aborted cycle never accepts a word.
  assign in_ready = (state_q == S_LOAD) && !abort;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    loaded_d  = loaded_q;
    settle_d  = settle_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef DBG_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    exp_d     = exp_q;
    sum_err_d = sum_err_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          addr_d   = base_addr;
          count_d  = word_count;
          loaded_d = '0;
          settle_d = '0;
`ifdef DBG_LOADER_CHECKSUM_EN
          sum_d     = '0;
          exp_d     = exp_sum;
          sum_err_d = 1'b0;
`endif
          if (word_count > CW'(MAX_WORDS)) state_d = S_ERROR;
          else if (word_count == '0)      state_d = S_SETTLE;
          else                            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          addr_d    = addr_q + IL'(ADDR_STEP);
          loaded_d  = loaded_q + CW'(1);
`ifdef DBG_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
`endif
          if (loaded_q + CW'(1) == count_q) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end
        end
      end
      S_SETTLE: begin
        // First SETTLE cycle coincides with the final write strobe.
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == SW'(SETTLE_CYCLES)) begin
`ifdef DBG_LOADER_CHECKSUM_EN
          if (sum_q != exp_q) begin
            state_d   = S_ERROR;
            sum_err_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
`else
          state_d = S_RUN;
`endif
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    core_rst_d = (state_d != S_RUN);
    done_d     = (state_d == S_RUN) && (state_q != S_RUN);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      loaded_q   <= '0;
      settle_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      exp_q      <= '0;
      sum_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      loaded_q   <= loaded_d;
      settle_q   <= settle_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef DBG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      sum_err_q  <= sum_err_d;
`endif
    end
  end

  assign dbg_wr_en    = wr_en_q;
  assign dbg_addr     = wr_addr_q;
  assign dbg_instr    = wr_data_q;
  assign core_rst     = core_rst_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_SETTLE);
  assign done         = done_q;
  assign error        = error_q;
  assign loaded_count = loaded_q;
  assign state_dbg    = state_q;
`ifdef DBG_LOADER_CHECKSUM_EN
  assign sum_err      = sum_err_q;
`endif
endmodule

// File: tb/tb_dbg_program_loader.sv
// Bench for dbg_program_loader: directed loads, write strobes checked by a
// scoreboard monitor against an expected {addr,data} queue.
module tb_dbg_program_loader;
  localparam int IL = 32;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IL-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          in_valid = 1'b0;
  logic [IL-1:0] in_data = '0;
  logic          in_ready;
  logic          dbg_wr_en;
  logic [IL-1:0] dbg_addr;
  logic [IL-1:0] dbg_instr;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] loaded_count;
  logic [2:0]    state_dbg;
`ifdef DBG_LOADER_CHECKSUM_EN
  logic [IL-1:0] exp_sum = '0;
  logic          sum_err;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [2*IL-1:0] exp_q[$];

  dbg_program_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error),
    .loaded_count(loaded_count),
`ifdef DBG_LOADER_CHECKSUM_EN
    .exp_sum(exp_sum), .sum_err(sum_err),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (dbg_wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got addr=%h data=%h, required no strobe", dbg_addr, dbg_instr);
        end else begin
          logic [2*IL-1:0] e;
          e = exp_q.pop_front();
          if ({dbg_addr, dbg_instr} !== e) begin
            errors++;
            $display("FAIL strobe: got addr=%h data=%h, required addr=%h data=%h",
                     dbg_addr, dbg_instr, e[2*IL-1:IL], e[IL-1:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_start(input logic [IL-1:0] base, input logic [CW-1:0] cnt);
    start = 1'b1;
    base_addr = base;
    word_count = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [IL-1:0] addr, input logic [IL-1:0] data, input bit drop);
    int waited = 0;
    in_valid = 1'b1;
    in_data = data;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=0 after %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back({addr, data});
      tick();
    end
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (core_rst && n < 20) begin
      tick();
      n++;
    end
    check(name, core_rst, 0);
  endtask

  // Stimulus
  initial begin
    int d0;
    tick();
    tick();
    check("rst_core_rst", core_rst, 1);
    check("rst_wr_en", dbg_wr_en, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, error}, 0);
    check("rst_loaded", loaded_count, 0);
    rst = 1'b1;
    tick();

    // Single word, timing of core release and done pulse
    d0 = done_cnt;
    do_start(32'h0, 11'd1);
    check("load_busy", busy, 1);
    send_word(32'h0, 32'h0020_B0B7, 1);
    check("strobe_now", dbg_wr_en, 1);
    check("strobe_core_rst", core_rst, 1);
    check("strobe_in_ready", in_ready, 0);
    tick();
    check("settle_core_rst", core_rst, 1);
    check("settle_done", done, 0);
    tick();
    check("release_core_rst", core_rst, 0);
    check("release_done", done, 1);
    check("release_busy", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("done_pulses", done_cnt - d0, 1);
    check("loaded_1", loaded_count, 1);

    // Back-to-back words give contiguous strobes; start while busy ignored
    do_start(32'h100, 11'd4);
    check("reload_core_rst", core_rst, 1);
    send_word(32'h100, 32'hA000_0001, 0);
    check("contig_0", dbg_wr_en, 1);
    start = 1'b1;
    word_count = 11'd1;
    send_word(32'h104, 32'hA000_0002, 0);
    start = 1'b0;
    check("contig_1", dbg_wr_en, 1);
    send_word(32'h108, 32'hA000_0003, 0);
    check("contig_2", dbg_wr_en, 1);
    send_word(32'h10C, 32'hA000_0004, 1);
    check("contig_3", dbg_wr_en, 1);
    check("loaded_4", loaded_count, 4);
    wait_run("run_after_4");

    // Gapped input keeps order
    do_start(32'h300, 11'd3);
    send_word(32'h300, 32'hB000_0001, 1);
    tick(); tick();
    check("gap_no_strobe", dbg_wr_en, 0);
    send_word(32'h304, 32'hB000_0002, 1);
    tick();
    send_word(32'h308, 32'hB000_0003, 1);
    wait_run("run_after_gaps");

    // Address wraps
    do_start(32'hFFFF_FFFC, 11'd2);
    send_word(32'hFFFF_FFFC, 32'hC000_0001, 0);
    send_word(32'h0000_0000, 32'hC000_0002, 1);
    wait_run("run_after_wrap");

    // Abort after 2 of 4; the word offered with abort is not accepted
    do_start(32'h200, 11'd4);
    send_word(32'h200, 32'hD000_0001, 0);
    send_word(32'h204, 32'hD000_0002, 0);
    in_data = 32'hD000_0003;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_core_rst", core_rst, 1);
    check("abort_loaded", loaded_count, 2);
    tick();
    check("abort_in_ready", in_ready, 0);

    // Oversize count goes to ERROR with no strobes
    do_start(32'h0, 11'd1025);
    check("oversize_error", error, 1);
    check("oversize_core_rst", core_rst, 1);
    check("oversize_busy", busy, 0);
    tick(); tick();
    check("error_sticky", error, 1);

    // Restart from ERROR, then reload from RUN
    do_start(32'h40, 11'd1);
    check("error_cleared", error, 0);
    send_word(32'h40, 32'hE000_0001, 1);
    wait_run("run_from_error");
    do_start(32'h80, 11'd1);
    check("run_reload_core_rst", core_rst, 1);
    check("run_reload_loaded", loaded_count, 0);
    send_word(32'h80, 32'hE000_0002, 1);
    wait_run("run_after_reload");

    // Zero-length load releases the core without strobes
    do_start(32'h500, 11'd0);
    check("zero_busy", busy, 1);
    wait_run("run_after_zero");

`ifdef DBG_LOADER_CHECKSUM_EN
    exp_sum = 32'd6;
    do_start(32'h600, 11'd3);
    send_word(32'h600, 32'd1, 0);
    send_word(32'h604, 32'd2, 0);
    send_word(32'h608, 32'd3, 1);
    wait_run("sum_ok_run");
    check("sum_ok_flag", sum_err, 0);
    exp_sum = 32'd7;
    do_start(32'h600, 11'd3);
    send_word(32'h600, 32'd1, 0);
    send_word(32'h604, 32'd2, 0);
    send_word(32'h608, 32'd3, 1);
    tick(); tick();
    check("sum_bad_err", {sum_err, error}, 2'b11);
    check("sum_bad_core_rst", core_rst, 1);
`endif

    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
